// File: rtl/tx_word_serializer.sv
// Word-to-bit serializer for a per-lane transmit stage: small word FIFO feeding
// an LSB-first shifter, with a bit-valid qualifier and a saturating underrun count.
module tx_word_serializer #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                         hs_clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic                         ser_bit,
    output logic                         ser_valid,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_W-1:0]             underrun_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned REM_W = $clog2(WORD_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WORD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [WORD_W-1:0]  sreg;
    logic [REM_W-1:0]   rem;
    logic [WORD_W-1:0]  head;
    logic               fifo_empty;
    logic               load_slot;
    logic               push;
    logic               pop;

    assign fifo_empty = (fifo_level == '0);
    assign in_ready   = (fifo_level != LVL_W'(DEPTH)) && !flush;
    assign push       = in_valid && in_ready;
    // The shifter takes a new word when idle or when the last bit is on the wire.
    assign load_slot  = (state == IDLE) || (rem == '0);
    assign pop        = !flush && load_slot && !fifo_empty;
    assign head       = mem[rd_ptr];

    // Word storage; write-only path, no bypass to the shifter.
    always_ff @(posedge hs_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge hs_clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Shifter FSM with registered serial outputs and underrun accounting.
    always_ff @(posedge hs_clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            sreg         <= '0;
            rem          <= '0;
            ser_bit      <= 1'b0;
            ser_valid    <= 1'b0;
            underrun_cnt <= '0;
        end else if (flush) begin
            state     <= IDLE;
            sreg      <= '0;
            rem       <= '0;
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        ser_bit   <= head[0];
                        ser_valid <= 1'b1;
                        sreg      <= head >> 1;
                        rem       <= REM_W'(WORD_W - 1);
                        state     <= SHIFT;
                    end else begin
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (rem != '0) begin
                        ser_bit <= sreg[0];
                        sreg    <= sreg >> 1;
                        rem     <= rem - REM_W'(1);
                    end else if (pop) begin
                        ser_bit   <= head[0];
                        ser_valid <= 1'b1;
                        sreg      <= head >> 1;
                        rem       <= REM_W'(WORD_W - 1);
                    end else begin
                        // Stream ran dry at a word boundary: one underrun per stream end.
                        ser_bit   <= 1'b0;
                        ser_valid <= 1'b0;
                        state     <= IDLE;
                        if (underrun_cnt != '1) begin
                            underrun_cnt <= underrun_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ser_bit   <= 1'b0;
                    ser_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
